seq_shift_mul: RTL and testbench

//  Sequential shift-and-add multiplier: one start pulse launches an N-iteration multiply; done pulses once, product holds.

---
 rtl/seq_shift_mul_pkg.sv | 17 +
 rtl/seq_shift_mul_shift_reg_lr.sv | 31 +++
 rtl/seq_shift_mul.sv | 146 ++++++++++++++
 tb/tb_seq_shift_mul.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/seq_shift_mul_pkg.sv
// Shared definitions for the multi-cycle execute units: FSM state encoding
// and the counter-width helper. Unused encoding 2'd3 is treated as IDLE by
// every FSM that imports this package.
package seq_shift_mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Iteration counter width; never below one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_shift_mul_shift_reg_lr.sv
// shift_reg_lr: W-bit register with parallel load and 1-bit logical shift.
// Latency: one cycle from load/shift to q. DIR 0 shifts left, DIR 1 right.
// No backpressure; load has priority over shift; synchronous active-high reset.
module shift_reg_lr #(
    parameter int W   = 8,
    parameter int DIR = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;

    // Register with load-over-shift priority; zero fill on the vacated bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else if (load) begin
            q_q <= d;
        end else if (shift) begin
            q_q <= (DIR == 0) ? (q_q << 1) : (q_q >> 1);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/seq_shift_mul.sv
// seq_shift_mul: shift-and-add multiplier, one adder, N iterations per product.
// Latency: start accepted at edge t -> done pulses in the cycle after edge t+N.
// No queueing: start is ignored while busy. Optional macro SEQ_MUL_SIGNED_EN.
module seq_shift_mul
    import seq_shift_mul_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int            CW       = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*N-1:0]  acc_q, acc_d;
    logic [2*N-1:0]  product_q, product_d;

    logic            accept;
    logic            shift_en;
    logic [N-1:0]    a_mag, b_mag;
    logic [2*N-1:0]  mcand_q;
    logic [N-1:0]    mplier_q;
    logic [2*N-1:0]  acc_sum;
    logic [2*N-1:0]  result;

`ifdef SEQ_MUL_SIGNED_EN
    logic neg_q, neg_d;

    // Two's complement operands are reduced to magnitudes; -2^(N-1) maps to
    // 2^(N-1), which still fits as N-bit unsigned.
    always_comb begin
        a_mag = multiplicand[N-1] ? -multiplicand : multiplicand;
        b_mag = multiplier[N-1]   ? -multiplier   : multiplier;
    end
`else
    assign a_mag = multiplicand;
    assign b_mag = multiplier;
`endif

    shift_reg_lr #(.W(2*N), .DIR(0)) u_mcand_sr (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift_en),
        .d     ({{N{1'b0}}, a_mag}),
        .q     (mcand_q)
    );

    shift_reg_lr #(.W(N), .DIR(1)) u_mplier_sr (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift_en),
        .d     (b_mag),
        .q     (mplier_q)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: fixed N-cycle RUN, single DONE cycle, stray code -> IDLE.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: state_d = start ? S_RUN : S_IDLE;
            S_RUN:  state_d = (cnt_q == CNT_LAST) ? S_DONE : S_RUN;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake flags and datapath enables.
    always_comb begin
        accept   = (state_q == S_IDLE) && start;
        shift_en = (state_q == S_RUN);
        busy     = (state_q == S_RUN) || (state_q == S_DONE);
        done     = (state_q == S_DONE);
    end

    // Partial-product add; top N bits of the sum never carry out.
    always_comb begin
        acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef SEQ_MUL_SIGNED_EN
        result  = neg_q ? -acc_sum : acc_sum;
`else
        result  = acc_sum;
`endif
    end

    // Datapath next state: clear on accept, iterate in RUN, commit on last.
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        product_d = product_q;
`ifdef SEQ_MUL_SIGNED_EN
        neg_d     = neg_q;
`endif
        if (accept) begin
            cnt_d = '0;
            acc_d = '0;
`ifdef SEQ_MUL_SIGNED_EN
            neg_d = multiplicand[N-1] ^ multiplier[N-1];
`endif
        end else if (shift_en) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = acc_sum;
            if (cnt_q == CNT_LAST) begin
                product_d = result;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            product_q <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            product_q <= product_d;
`ifdef SEQ_MUL_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_seq_shift_mul.sv
// Directed bench for seq_shift_mul (N=8): reset, products, latency,
// ignored start while busy, mid-run reset, back-to-back issue.
module tb_seq_shift_mul;

    localparam int N = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    seq_shift_mul #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply, check latency, product, done width, return to IDLE.
    // Leaves the bench in the IDLE cycle right after DONE.
    task automatic run_mul(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [2*N-1:0] exp, output int accept_cyc);
        int lat;
        start = 1'b1; multiplicand = a; multiplier = b;
        step();
        accept_cyc = cyc;
        start = 1'b0; multiplicand = 8'hA5; multiplier = 8'h5A;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(N));
        chk({tag, "_prod"}, 32'(product), 32'(exp));
        step();
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, 32'(product), 32'(exp));
    endtask

    initial begin
        int t0, t1, lat, npulse;
        rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_prod", 32'(product), 32'd0);
        rst = 1'b0;
        step();

        run_mul("m13x11", 8'd13, 8'd11, 16'd143, t0);
`ifndef SEQ_MUL_SIGNED_EN
        run_mul("m255x255", 8'd255, 8'd255, 16'hFE01, t0);
        run_mul("m0x200", 8'd0, 8'd200, 16'd0, t0);
        run_mul("m77x1", 8'd77, 8'd1, 16'd77, t0);
`endif

        // Start pulse during RUN cycle 3 must be ignored.
        start = 1'b1; multiplicand = 8'd13; multiplier = 8'd11;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1; multiplicand = 8'd2; multiplier = 8'd2;
        step();
        start = 1'b0;
        lat = 3; npulse = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        chk("ign_lat", 32'(lat), 32'(N));
        chk("ign_prod", 32'(product), 32'd143);
        for (int i = 0; i < 2 * N; i++) begin
            if (done) npulse++;
            step();
        end
        chk("ign_pulses", 32'(npulse), 32'd1);
        chk("ign_hold", 32'(product), 32'd143);

        // Reset in RUN cycle 4 aborts the operation.
        start = 1'b1; multiplicand = 8'd9; multiplier = 8'd9;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_prod", 32'(product), 32'd0);
        rst = 1'b0;
        npulse = 0;
        for (int i = 0; i < N + 2; i++) begin
            if (done) npulse++;
            step();
        end
        chk("abort_nodone", 32'(npulse), 32'd0);
        run_mul("m6x7", 8'd6, 8'd7, 16'd42, t0);

        // Back-to-back issue at the minimum interval.
        run_mul("b2b_3x4", 8'd3, 8'd4, 16'd12, t0);
        run_mul("b2b_5x5", 8'd5, 8'd5, 16'd25, t1);
        chk("b2b_interval", 32'(t1 - t0), 32'(N + 2));

`ifdef SEQ_MUL_SIGNED_EN
        run_mul("s_m3x5", 8'hFD, 8'd5, 16'hFFF1, t0);
        run_mul("s_m128xm128", 8'h80, 8'h80, 16'h4000, t0);
        run_mul("s_m128x1", 8'h80, 8'd1, 16'hFF80, t0);
        run_mul("s_7xm1", 8'd7, 8'hFF, 16'hFFF9, t0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
